// File: rtl/expr_string_tx_pkg.sv
// Shared definitions for the expression-string transmitter and recognizer:
// ASCII codes of the characters that appear on the bus and the FSM states.
package expr_string_tx_pkg;

    localparam logic [7:0] CH_0    = 8'd48;  // '0'
    localparam logic [7:0] CH_PLUS = 8'd43;  // '+'
    localparam logic [7:0] CH_MUL  = 8'd42;  // '*'

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIG  = 2'd1,
        OPR  = 2'd2
    } state_t;

endpackage

// File: rtl/expr_char_sel.sv
// Character selector: maps the transmitter state and term index onto the
// ASCII byte currently presented and the end-of-string marker.
module expr_char_sel
    import expr_string_tx_pkg::*;
#(
    parameter int MAX_TERMS = 8,
    parameter int CW        = 4
) (
    input  state_t                   state,
    input  logic [CW-1:0]            k,
    input  logic [CW-1:0]            n,
    input  logic [4*MAX_TERMS-1:0]   digits,
    input  logic [MAX_TERMS-2:0]     ops,
    output logic [7:0]               out,
    output logic                     last
);

    logic [3:0] digit;
    logic       op;

    // Pick digit k / operator k and encode the character for the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        out   = 8'd0;
        last  = 1'b0;
        digit = 4'd0;
        op    = 1'b0;
        for (int i = 0; i < MAX_TERMS; i++) begin
            if (k == CW'(i)) digit = digits[4*i +: 4];
        end
        for (int i = 0; i < MAX_TERMS - 1; i++) begin
            if (k == CW'(i)) op = ops[i];
        end
        case (state)
            DIG: begin
                out  = CH_0 + {4'd0, digit};
                last = (k == n - CW'(1));
            end
            OPR:     out = op ? CH_MUL : CH_PLUS;
            default: ;
        endcase
    end

endmodule

// File: rtl/expr_string_tx.sv
// Expression-string transmitter: validates and latches a parallel expression,
// then serialises it as digit, operator, digit, ... over a valid/ready bus.
module expr_string_tx
    import expr_string_tx_pkg::*;
#(
    parameter int MAX_TERMS = 8,
    parameter int CW        = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     start,
    input  logic [CW-1:0]            num_terms,
    input  logic [4*MAX_TERMS-1:0]   digits,
    input  logic [MAX_TERMS-2:0]     ops,
    output logic                     busy,
    output logic [7:0]               out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     last,
    output logic                     err
);

    state_t                 state;
    logic [CW-1:0]          k;
    logic [CW-1:0]          n_q;
    logic [4*MAX_TERMS-1:0] digits_q;
    logic [MAX_TERMS-2:0]   ops_q;
    logic                   start_ok;
    logic                   final_char;

    // Request validation: term count in range and every used digit decimal.
    always_comb begin
        start_ok = (num_terms != '0) && (num_terms <= CW'(MAX_TERMS));
        for (int i = 0; i < MAX_TERMS; i++) begin
            if ((CW'(i) < num_terms) && (digits[4*i +: 4] > 4'd9)) start_ok = 1'b0;
        end
    end

    assign final_char = (k == n_q - CW'(1));

    // Transmit FSM, term index, request latches and status flags.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            k         <= '0;
            // NOTE: the request latches are cleared too; they are a handful of flops, not a RAM.
            n_q       <= '0;
            digits_q  <= '0;
            ops_q     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            n_q       <= num_terms;
                            digits_q  <= digits;
                            ops_q     <= ops;
                            k         <= '0;
                            state     <= DIG;
                            busy      <= 1'b1;
                            out_valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                DIG: begin
                    if (out_ready) begin
                        if (final_char) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            k         <= '0;
                        end else begin
                            state <= OPR;
                        end
                    end
                end
                OPR: begin
                    if (out_ready) begin
                        k     <= k + CW'(1);
                        state <= DIG;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    expr_char_sel #(
        .MAX_TERMS (MAX_TERMS),
        .CW        (CW)
    ) u_char_sel (
        .state  (state),
        .k      (k),
        .n      (n_q),
        .digits (digits_q),
        .ops    (ops_q),
        .out    (out),
        .last   (last)
    );

endmodule

// File: doc/expr_string_tx.md
Name: expr_string_tx

Overview:
Transmitter counterpart of the expression-string recognizer FSM. It takes a whole expression as parallel operands and operators and serialises it as one ASCII character per transfer: digit, operator, digit, and so on. Output uses a valid/ready handshake. Every string it emits is accepted by the recognizer, which drives out=1 after each digit. It sits between a test or control source and the recognizer input bus.

Parameters:
MAX_TERMS, 8, maximum digits per expression (>=2)
CW, 4, width of num_terms; must satisfy 2^CW > MAX_TERMS

Ports:
clk  input  1  clock, rising edge
clr  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only when busy=0
num_terms  input  CW  number of digits n, legal range 1..MAX_TERMS
digits  input  4*MAX_TERMS  digit i at [4i+3:4i]; digit 0 is sent first
ops  input  MAX_TERMS-1  op i sits between digit i and digit i+1; 0='+' (43), 1='*' (42)
busy  output  1  high from acceptance until the final handshake
out  output  8  ASCII character
out_valid  output  1  out holds a character
out_ready  input  1  consumer accepts the character this cycle
last  output  1  high together with out_valid on the final character
err  output  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE; busy=0, out=8'd0, out_valid=0, last=0, err=0; index=0.
- States:
  - IDLE
  - DIG: presenting digit k
  - OPR: presenting operator k
- IDLE with start=1:
  - Reject if num_terms==0, num_terms>MAX_TERMS, or any digit i<num_terms is >9.
  - On reject: next cycle err=1 for one cycle; stay IDLE; no output.
  - Otherwise, on that edge: latch num_terms, digits and ops; set k=0; go to DIG; busy=1; out_valid=1; out=48+digit0.
  - Latency from start to first valid character: 1 cycle.
- DIG with out_valid && out_ready:
  - If k==n-1: this was the final character. Go to IDLE; out_valid=0, busy=0, last=0, out=0 on the same edge.
  - Else: go to OPR; out=(op k ? 42 : 43).
- OPR with a handshake: k<=k+1; go to DIG; out=48+digit(k+1).
- last = out_valid && state==DIG && k==n-1.
- Backpressure: while out_valid=1 and out_ready=0, out and last hold stable and state does not change.
- Full throughput: with out_ready held at 1, one character per cycle. Total characters = 2n-1.
- start while busy=1 is ignored. Latched inputs are unaffected by later changes on digits, ops or num_terms.
- n=1: a single digit character with last=1, and no operator.
- A new start is accepted in the cycle after the final handshake (IDLE), giving a 1-cycle gap between strings.
- Reset mid-string aborts immediately. Outputs clear, and no partial-string completion is signalled.
- ops bits at index >= n-1 are don't-care; digits at index >= n are not range-checked.

Decomposition:
- Shared package holds:
  - ASCII constants: CH_0=48, CH_PLUS=43, CH_MUL=42
  - State encoding: IDLE, DIG, OPR
- The same package is reused by the recognizer and its bench.
- One natural sub-module: expr_char_sel, the combinational selector. It takes state, k and the latched vectors, and produces the out byte and last.
- Main block keeps the FSM, index counter, latch registers and validation logic.

Test Plan:
- Basic string: n=3, digits {2,7,5} (digit0=2), ops {0,1}, out_ready=1. Required out sequence: 50,43,55,42,53 on consecutive cycles; last=1 only on 53; busy falls on the edge after 53.
- Backpressure: same request, out_ready toggling 1,0,0,1,... Each character holds stable during ready=0; the sequence is unchanged; no duplicated or dropped character.
- Rejects: n=2 with digit1=4'hA gives err pulse of 1 cycle, out_valid stays 0, busy stays 0. num_terms=0 and num_terms=9 give the same response.
- Boundary n: n=1 with digit 9 gives a single 57 with last=1. n=MAX_TERMS gives 15 characters and last on the 15th.
- Mid-operation: start pulse during busy is ignored. Assert clr=0 after the 2nd handshake: out_valid=0 and out=0 immediately (asynchronously). After release, a new start is served from digit0.
- Loopback: connect out to the recognizer's in, clocked on handshake cycles, over 200 random legal requests. The recognizer's out=1 after every digit and 0 after every operator.
